ps2_pad_responder: RTL
======================

// Module: ps2_pad_responder
// PURPOSE
//  Device-side (responder) end of the PS2 gamepad serial link: emulates an analog pad (ID 0x73) to an FPGA host.
//  Host drives scs/sclk/cmd; block returns the 9-byte poll frame on dat, LSB first, from parallel button/stick inputs.
//  Used as a loopback target for the pad host reader and as a pad stand-in on a second board.
// PARAMETERS
//  SYNC_STAGES  2     flops per input synchronizer (scs, sclk, cmd); min 2
//  ACK_CYCLES   120   ack_n low width in CLK_40M cycles (3 us)
//  PAD_ID       8'h73 byte 1 response (analog mode)
//  NUM_BYTES    9     bytes per poll frame incl. header
// PORTS
//  CLK_40M     in   1   system clock, 40 MHz
//  rst         in   1   synchronous, active-low reset
//  scs         in   1   host chip select, active low, async to CLK_40M
//  sclk        in   1   host serial clock, idles high, async
//  cmd         in   1   host command bit, LSB first, async
//  dat         out  1   response bit to host, LSB first, idles 1
//  ack_n       out  1   per-byte acknowledge, active low
//  buttons     in   16  pressed=1; [7:0]->byte3, [15:8]->byte4 (circle=[13], square=[15]); sent inverted
//  rx,ry,lx,ly in   8   stick positions, 0x80 = centre
//  frame_done  out  1   1-cycle pulse: 9th byte completed with valid header
//  cmd_err     out  1   1-cycle pulse: byte0!=0x01 or byte1!=0x42
// BEHAVIOUR
//  Reset (rst=0 at CLK_40M edge): dat=1, ack_n=1, frame_done=0, cmd_err=0, state=IDLE, counters 0, sync flops=1.
//  Inputs pass SYNC_STAGES-flop synchronizers; edges detected on synchronized sclk/scs (1-cycle strobes).
//  Frame byte map: 0:FF 1:PAD_ID 2:5A 3:~buttons[7:0] 4:~buttons[15:8] 5:rx 6:ry 7:lx 8:ly.
//  Bytes 3..8 come from a snapshot of buttons/rx/ry/lx/ly taken on the scs falling strobe; later input changes ignored.
//  Bit timing: dat changes only in the cycle after a synchronized sclk rising strobe; stable for the whole low phase.
//  cmd sampled on sclk rising strobe into 8-bit shift reg (LSB first); bit counter 0..7, byte counter 0..NUM_BYTES.
//  FSM:
//   IDLE  : dat=1. scs falling -> take snapshot, byte=0, bit=0, dat=bit0 of byte0 (1) -> SHIFT.
//   SHIFT : each sclk rise: capture cmd, bit++, dat=next bit. After 8th rise: check header, byte++;
//           byte0 rx !=0x01 or byte1 rx !=0x42 -> cmd_err pulse -> DRAIN;
//           byte now == NUM_BYTES -> frame_done pulse (if header ok) -> DRAIN, no ack;
//           else dat=bit0 of next byte, ack_n=0 -> ACK.
//   ACK   : ack_n low ACK_CYCLES cycles then 1 -> SHIFT. sclk edges during ACK still processed (ack cut short, ack_n=1).
//   DRAIN : dat=1, ack_n=1, further sclk edges ignored (overrun bytes read as 0xFF).
//  scs rising strobe in any state: abort -> IDLE next cycle, dat=1, ack_n=1, no frame_done; partial frame discarded.
//  scs falling while not IDLE (no rise seen): treated as new frame start, counters cleared.
//  sclk edges while scs high ignored. Simultaneous scs rise + sclk rise: abort wins.
//  rst=0 mid-frame: immediate return to reset values; host must re-assert scs for a new frame.
//  frame_done and cmd_err mutually exclusive per frame; each at most once per frame.
// TESTING
//  T1 reset: rst=0 2 cycles, scs=1 -> dat=1, ack_n=1, frame_done=0, cmd_err=0.
//  T2 poll: buttons=16'h2000, rx=12 ry=34 lx=AB ly=56 (hex), cmd 01 42 00x7 at 6 us half-period
//     -> host reads FF 73 5A FF DF 12 34 AB 56; 8 ack_n pulses of 120 cycles; one frame_done.
//  T3 bad cmd: cmd 01 43 .. -> bytes 0-1 FF 73, bytes 2-8 FF, ack only after byte0, one cmd_err, no frame_done.
//  T4 abort: scs rises after byte 4 -> dat=1 within SYNC_STAGES+2 cycles, no frame_done; next full frame correct.
//  T5 snapshot: change lx 0xAB->0x10 during byte 2 -> byte7 reads 0xAB; following frame reads 0x10.
//  T6 overrun: 10th byte clocked -> 0xFF, no ack_n pulse, single frame_done.

Source files
------------

// File: rtl/ps2_pad_responder.sv
// ps2_pad_responder: device end of the PS2 gamepad link, emulating an analog pad.
// Answers each host poll with the 9-byte frame built from a snapshot of the button/stick inputs.
module ps2_pad_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         ACK_CYCLES  = 120,
    parameter logic [7:0] PAD_ID      = 8'h73,
    parameter int         NUM_BYTES   = 9
) (
    input  logic        CLK_40M,
    input  logic        rst,
    input  logic        scs,
    input  logic        sclk,
    input  logic        cmd,
    output logic        dat,
    output logic        ack_n,
    input  logic [15:0] buttons,
    input  logic [7:0]  rx,
    input  logic [7:0]  ry,
    input  logic [7:0]  lx,
    input  logic [7:0]  ly,
    output logic        frame_done,
    output logic        cmd_err
);

    localparam int BW = $clog2(NUM_BYTES + 1);
    localparam int AW = $clog2(ACK_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACK, DRAIN} state_t;

    logic [SYNC_STAGES-1:0] r_scsSync;
    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_cmdSync;
    logic                   r_scsPrev;
    logic                   r_sclkPrev;

    logic w_scs;
    logic w_sclk;
    logic w_cmd;
    logic w_scsFall;
    logic w_scsRise;
    logic w_sclkRise;

    state_t          r_state;
    logic            r_dat;
    logic            r_ackN;
    logic            r_frameDone;
    logic            r_cmdErr;
    logic [2:0]      r_bitCnt;
    logic [BW-1:0]   r_byteCnt;
    logic [AW-1:0]   r_ackCnt;
    logic [6:0]      r_rxShift;
    logic [7:0]      r_txByte;
    logic [15:0]     r_snapBtn;
    logic [7:0]      r_snapRx;
    logic [7:0]      r_snapRy;
    logic [7:0]      r_snapLx;
    logic [7:0]      r_snapLy;

    logic [7:0]      w_rxByte;
    logic [2:0]      w_bitNext;
    logic [BW-1:0]   w_byteNext;
    logic [7:0]      w_nextByteVal;
    logic            w_hdrBad;

    always_ff @(posedge CLK_40M) begin
        if (!rst) begin
            r_scsSync  <= '1;
            r_sclkSync <= '1;
            r_cmdSync  <= '1;
            r_scsPrev  <= 1'b1;
            r_sclkPrev <= 1'b1;
        end else begin
            r_scsSync  <= {r_scsSync[SYNC_STAGES-2:0], scs};
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
            r_cmdSync  <= {r_cmdSync[SYNC_STAGES-2:0], cmd};
            r_scsPrev  <= w_scs;
            r_sclkPrev <= w_sclk;
        end
    end

    assign w_scs      = r_scsSync[SYNC_STAGES-1];
    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_cmd      = r_cmdSync[SYNC_STAGES-1];
    assign w_scsFall  = r_scsPrev & ~w_scs;
    assign w_scsRise  = ~r_scsPrev & w_scs;
    assign w_sclkRise = ~r_sclkPrev & w_sclk & ~w_scs;

    // The 8th cmd bit is still in the synchronizer when the byte completes, so splice it in directly.
    assign w_rxByte   = {w_cmd, r_rxShift};
    assign w_bitNext  = r_bitCnt + 3'd1;
    assign w_byteNext = r_byteCnt + BW'(1);
    assign w_hdrBad   = ((r_byteCnt == BW'(0)) && (w_rxByte != 8'h01)) ||
                        ((r_byteCnt == BW'(1)) && (w_rxByte != 8'h42));

    always_comb begin
        w_nextByteVal = 8'hFF;
        case (int'(w_byteNext))
            1:       w_nextByteVal = PAD_ID;
            2:       w_nextByteVal = 8'h5A;
            3:       w_nextByteVal = ~r_snapBtn[7:0];
            4:       w_nextByteVal = ~r_snapBtn[15:8];
            5:       w_nextByteVal = r_snapRx;
            6:       w_nextByteVal = r_snapRy;
            7:       w_nextByteVal = r_snapLx;
            8:       w_nextByteVal = r_snapLy;
            default: w_nextByteVal = 8'hFF;
        endcase
    end

    // Abort on scs rise outranks everything else, including a coincident sclk rise.
    always_ff @(posedge CLK_40M) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dat       <= 1'b1;
            r_ackN      <= 1'b1;
            r_frameDone <= 1'b0;
            r_cmdErr    <= 1'b0;
            r_bitCnt    <= '0;
            r_byteCnt   <= '0;
            r_ackCnt    <= '0;
            r_rxShift   <= '0;
            r_txByte    <= 8'hFF;
            r_snapBtn   <= '0;
            r_snapRx    <= '0;
            r_snapRy    <= '0;
            r_snapLx    <= '0;
            r_snapLy    <= '0;
        end else begin
            r_frameDone <= 1'b0;
            r_cmdErr    <= 1'b0;
            if (w_scsRise) begin
                r_state <= IDLE;
                r_dat   <= 1'b1;
                r_ackN  <= 1'b1;
            end else if (w_scsFall) begin
                r_snapBtn <= buttons;
                r_snapRx  <= rx;
                r_snapRy  <= ry;
                r_snapLx  <= lx;
                r_snapLy  <= ly;
                r_byteCnt <= '0;
                r_bitCnt  <= '0;
                r_ackCnt  <= '0;
                r_rxShift <= '0;
                r_txByte  <= 8'hFF;
                r_dat     <= 1'b1;
                r_ackN    <= 1'b1;
                r_state   <= SHIFT;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_dat  <= 1'b1;
                        r_ackN <= 1'b1;
                    end
                    SHIFT, ACK: begin
                        if (r_state == ACK) begin
                            if (r_ackCnt == ACK_LAST) begin
                                r_ackN  <= 1'b1;
                                r_state <= SHIFT;
                            end else begin
                                r_ackCnt <= r_ackCnt + AW'(1);
                            end
                        end
                        if (w_sclkRise) begin
                            r_ackN    <= 1'b1;
                            r_rxShift <= {w_cmd, r_rxShift[6:1]};
                            if (r_bitCnt == 3'd7) begin
                                r_bitCnt  <= '0;
                                r_byteCnt <= w_byteNext;
                                if (w_hdrBad) begin
                                    r_cmdErr <= 1'b1;
                                    r_dat    <= 1'b1;
                                    r_state  <= DRAIN;
                                end else if (w_byteNext == LAST_BYTE) begin
                                    r_frameDone <= 1'b1;
                                    r_dat       <= 1'b1;
                                    r_state     <= DRAIN;
                                end else begin
                                    r_txByte <= w_nextByteVal;
                                    r_dat    <= w_nextByteVal[0];
                                    r_ackN   <= 1'b0;
                                    r_ackCnt <= '0;
                                    r_state  <= ACK;
                                end
                            end else begin
                                r_bitCnt <= w_bitNext;
                                r_dat    <= r_txByte[w_bitNext];
                                r_state  <= SHIFT;
                            end
                        end
                    end
                    DRAIN: begin
                        r_dat  <= 1'b1;
                        r_ackN <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_dat   <= 1'b1;
                        r_ackN  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dat        = r_dat;
    assign ack_n      = r_ackN;
    assign frame_done = r_frameDone;
    assign cmd_err    = r_cmdErr;

endmodule
